piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in serial-out shift register; the transmit-side counterpart of the sipo block.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on q, with a qualifying q_valid strobe.
- Feeds serial links whose far end is a sipo-style deserializer; back-to-back words stream with no idle gap.

Parameters:
- WIDTH, 4, data word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion synchronous to clk is the integrator's job.
- din  input  WIDTH  parallel word to serialize; sampled only on handshake.
- load_valid  input  1  producer has a word on din.
- load_ready  output  1  block can accept a word this cycle.
- q  output  1  serial data bit (registered).
- q_valid  output  1  q carries a valid bit this cycle (registered).
- done  output  1  one-cycle pulse coincident with the final serial bit of a word.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - q=0, q_valid=0, done=0.
  - load_ready=1 once reset is released.
- States: IDLE, SHIFT.
- Handshake:
  - Accept occurs at a rising edge where load_valid=1 and load_ready=1.
  - din is captured only then; load_valid with load_ready=0 is ignored, and din is not sampled.
  - load_ready = (state==IDLE) OR (state==SHIFT AND current bit is the last bit of the frame).
  - load_ready is combinational from state/counter only, never from load_valid.
- Latency:
  - The first bit of an accepted word is on q, with q_valid=1, in the cycle immediately after the accept edge.
  - Each subsequent edge advances one bit.
  - A frame occupies exactly FRAME cycles, where FRAME = WIDTH (WIDTH+1 with the optional feature).
- Bit order:
  - MSB_FIRST=1: din[WIDTH-1], din[WIDTH-2], ..., din[0].
  - MSB_FIRST=0: din[0] ... din[WIDTH-1].
- Counter:
  - $clog2(WIDTH+1) bits; counts 0..FRAME-1 within a frame.
  - Wraps to 0 on a new accept.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT at the last-bit edge if a new accept occurs (gapless: the next word's first bit follows immediately).
  - SHIFT -> IDLE at the last-bit edge with no accept; then q=0 and q_valid=0 the next cycle.
- done: high exactly during the last bit cycle of each frame. Back-to-back frames give one done pulse per frame.
- q is driven 0 whenever q_valid=0.
- Reset mid-frame: the frame is aborted immediately, the partial word is discarded, and outputs go to reset values. No done pulse is emitted.
- din changing after accept has no effect on the frame in flight.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra even-parity bit (XOR of all din bits captured at accept) is sent, with q_valid=1.
  - FRAME=WIDTH+1; done and the early load_ready move to the parity-bit cycle.
- Undefined:
  - No parity logic is instantiated; FRAME=WIDTH.
  - done and early load_ready align with the last data bit.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles, then release -> q=0, q_valid=0, done=0, load_ready=1; assert rst_n=0 asynchronously between edges -> outputs clear without waiting for clk.
- Single word, WIDTH=4, MSB_FIRST=1: din=4'b1011, load_valid pulsed 1 cycle -> q = 1,0,1,1 on 4 consecutive cycles starting the cycle after accept; q_valid=1 for exactly those 4 cycles; done=1 only on the 4th; then IDLE.
- LSB-first: MSB_FIRST=0, din=4'b1011 -> q = 1,1,0,1; done on the 4th bit.
- Back-to-back: load_valid held 1 with din=4'b1010, then 4'b0110 accepted during the last-bit cycle -> 8 contiguous valid bits 1,0,1,0,0,1,1,0; two done pulses on cycles 4 and 8; no gap cycle.
- Stall/ignore: load_valid=1 with din=4'b1111 during bit 2 of a frame -> not accepted, current frame unchanged; the word is accepted only at the last-bit edge.
- Parity (PISO_PARITY_EN defined): din=4'b1011 -> q = 1,0,1,1,1 over 5 cycles; done on the 5th. din=4'b1001 -> parity bit 0.
- Mid-frame reset: rst_n low during bit 2 of din=4'b1011, then release -> q_valid=0, no done; a new word 4'b0001 sends 0,0,0,1 correctly.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: valid/ready word load, one bit per clock on q, gapless framing.
// Optional PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FRAME - 2);
`ifdef PISO_PARITY_EN
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // cnt is the index within the frame of the bit currently on q
  assign last       = (state == SHIFT) && (cnt == LAST);
  assign load_ready = (state == IDLE) || last;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      done    <= 1'b0;
`ifdef PISO_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (accept) begin
      // first bit goes straight to q; sreg keeps the rest with the next bit at its head
      state   <= SHIFT;
      sreg    <= advance(din);
      cnt     <= '0;
      q       <= head_bit(din);
      q_valid <= 1'b1;
      done    <= 1'b0;
`ifdef PISO_PARITY_EN
      par     <= ^din;
`endif
    end else if (state == SHIFT) begin
      if (last) begin
        state   <= IDLE;
        sreg    <= '0;
        cnt     <= '0;
        q       <= 1'b0;
        q_valid <= 1'b0;
        done    <= 1'b0;
      end else begin
        cnt     <= cnt + 1'b1;
        sreg    <= advance(sreg);
        q       <= head_bit(sreg);
        q_valid <= 1'b1;
        done    <= (cnt == PRE_LAST);
`ifdef PISO_PARITY_EN
        if (cnt == DATA_LAST) q <= par;
`endif
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are checked
// against a queue-based frame model, a directed vector table and hand-written corner sequences.
module tb_piso_serializer;
  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             load_valid = 1'b0;
  logic             rdy_m, q_m, qv_m, done_m;
  logic             rdy_l, q_l, qv_l, done_l;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(rdy_m), .q(q_m), .q_valid(qv_m), .done(done_m));

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(rdy_l), .q(q_l), .q_valid(qv_l), .done(done_l));

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: each accepted word becomes FRAME queued {bit, last} entries that
  // appear on q one per cycle; the block is ready when nothing is left queued.
  typedef struct packed {logic b; logic d;} sbit_t;
  sbit_t pend_m[$];
  sbit_t pend_l[$];
  logic  eq_m, ev_m, ed_m, eq_l, ev_l, ed_l;

  function automatic logic frame_bit(input logic [WIDTH-1:0] w, input bit msb, input int i);
    if (i >= WIDTH) return ^w;
    return msb ? w[WIDTH-1-i] : w[i];
  endfunction

  task automatic model_reset();
    pend_m.delete();
    pend_l.delete();
    {eq_m, ev_m, ed_m, eq_l, ev_l, ed_l} = '0;
  endtask

  task automatic model_edge();
    sbit_t s;
    if (load_valid && pend_m.size() == 0) begin
      for (int i = 0; i < FRAME; i++) begin
        pend_m.push_back('{b: frame_bit(din, 1'b1, i), d: (i == FRAME - 1)});
        pend_l.push_back('{b: frame_bit(din, 1'b0, i), d: (i == FRAME - 1)});
      end
    end
    if (pend_m.size() > 0) begin
      s = pend_m.pop_front(); eq_m = s.b; ev_m = 1'b1; ed_m = s.d;
      s = pend_l.pop_front(); eq_l = s.b; ev_l = 1'b1; ed_l = s.d;
    end else begin
      {eq_m, ev_m, ed_m, eq_l, ev_l, ed_l} = '0;
    end
  endtask

  task automatic check_model();
    check("m_q",     q_m,    eq_m);
    check("m_valid", qv_m,   ev_m);
    check("m_done",  done_m, ed_m);
    check("m_ready", rdy_m,  pend_m.size() == 0);
    check("l_q",     q_l,    eq_l);
    check("l_valid", qv_l,   ev_l);
    check("l_done",  done_l, ed_l);
    check("l_ready", rdy_l,  pend_l.size() == 0);
  endtask

  task automatic cycle(input logic v, input logic [WIDTH-1:0] d);
    load_valid = v;
    din        = d;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             q;
    logic             qv;
    logic             dn;
    logic             rdy;
  } vec_t;

  vec_t             tbl[23];
  logic [FRAME-1:0] seq_m, seq_l;

  initial begin
    tbl[0]  = '{1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[18] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[22] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held for two edges, then released
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_q",     q_m,    1'b0);
    check("rst_valid", qv_m,   1'b0);
    check("rst_done",  done_m, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_m", rdy_m, 1'b1);
    check("rst_ready_l", rdy_l, 1'b1);
    cycle(1'b0, '0);

`ifndef PISO_PARITY_EN
    // Directed table: single word, back-to-back, stall/ignore
    for (int k = 0; k < 23; k++) begin
      cycle(tbl[k].v, tbl[k].d);
      check($sformatf("tbl%0d_q", k),     q_m,    tbl[k].q);
      check($sformatf("tbl%0d_valid", k), qv_m,   tbl[k].qv);
      check($sformatf("tbl%0d_done", k),  done_m, tbl[k].dn);
      check($sformatf("tbl%0d_ready", k), rdy_m,  tbl[k].rdy);
      if (k < 4) seq_l[3-k] = q_l;
    end
    check("lsb_first_1011", seq_l, 4'b1101);
`else
    // Parity frames: 1011 -> 1,0,1,1,1 and 1001 -> 1,0,0,1,0
    for (int k = 0; k < FRAME; k++) begin
      cycle(k == 0, 4'b1011);
      seq_m[FRAME-1-k] = q_m;
    end
    check("par_1011", seq_m, 5'b10111);
    check("par_1011_done", done_m, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      cycle(k == 0, 4'b1001);
      seq_m[FRAME-1-k] = q_m;
    end
    check("par_1001", seq_m, 5'b10010);
    cycle(1'b0, '0);
`endif

    // Asynchronous reset during bit 2 of a frame
    cycle(1'b1, 4'b1011);
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q",     q_m,    1'b0);
    check("arst_valid", qv_m,   1'b0);
    check("arst_done",  done_m, 1'b0);
    check("arst_valid_l", qv_l, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, '0);
    for (int k = 0; k < FRAME; k++) begin
      cycle(k == 0, 4'b0001);
      seq_m[FRAME-1-k] = q_m;
    end
    check("post_rst_0001", seq_m[FRAME-1 -: WIDTH], 4'b0001);
    cycle(1'b0, '0);

    // Randomized traffic against the frame model
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, WIDTH'($urandom));
    end
    repeat (FRAME + 1) cycle(1'b0, '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
